// File: rtl/key_capture_pkg.sv
// Shared types, keymap and one-hot helpers for the keypad capture block.
package key_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Indexed [row][col]; bit0 of C/R_press selects index 0.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/key_capture_decode.sv
// Combinational keypad decode: {column, row} one-hot pair to hex key code.
module keypad_decode
  import key_capture_pkg::*;
(
  input  logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] code,
  output logic       valid_combo
);

  always_comb begin
    valid_combo = onehot4(col) && onehot4(row);
    code        = KEYMAP[idx4(row)][idx4(col)];
  end

endmodule

// File: rtl/key_capture.sv
// Keypad receiver: debounces presses/releases, strobes key_valid once per key, keeps 2-digit history.
// Optional held-key auto-repeat is compiled in with `define KEY_AUTOREPEAT_EN.
//
// state   | meaning
// IDLE    | no key held, waiting for a valid press
// CONFIRM | candidate key seen, counting stable press cycles
// HELD    | key accepted, waiting for release
// RELEASE | key released, counting stable release cycles
module key_capture
  import key_capture_pkg::*;
#(
  parameter int               CNT_W         = 24,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = CNT_W'(5000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       C,
  input  logic [3:0]       R_press,
  input  logic             key_press,
  input  logic [CNT_W-1:0] debounce_cycles,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic [3:0]       digit_new,
  output logic [3:0]       digit_old,
  output logic             combo_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, eff;
  logic [3:0]       cand_q, cand_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       digit_new_q, digit_new_d;
  logic [3:0]       digit_old_q, digit_old_d;
  logic             combo_err_q, combo_err_d;
  logic [3:0]       code;
  logic             valid_combo;

`ifdef KEY_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_q, rpt_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  keypad_decode u_decode (
    .col         (C),
    .row         (R_press),
    .code        (code),
    .valid_combo (valid_combo)
  );

  assign eff = (debounce_cycles == '0) ? ONE : debounce_cycles;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    combo_err_d = (state_q == IDLE) && key_press && !valid_combo;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (key_press && valid_combo) begin
          state_d = CONFIRM;
          cand_d  = code;
          cnt_d   = ONE;
        end
      end
      CONFIRM: begin
        if (!key_press || code != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == eff) begin
          state_d     = HELD;
          key_valid_d = 1'b1;
          key_code_d  = cand_q;
          digit_old_d = digit_new_q;
          digit_new_d = cand_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!key_press) begin
          state_d = RELEASE;
          cnt_d   = ONE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt_q == REPEAT_CYCLES - ONE) begin
          key_valid_d = 1'b1;
          digit_old_d = digit_new_q;
          digit_new_d = key_code_q;
        end else begin
          rpt_d = rpt_q + ONE;
        end
`endif
      end
      RELEASE: begin
        // A press seen mid-release is contact bounce on the same key, not a new key.
        if (key_press) begin
          state_d = HELD;
        end else if (cnt_q == eff) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
      combo_err_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      combo_err_q <= combo_err_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign combo_err = combo_err_q;

endmodule
